// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and default sizing for the data-memory round-robin arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int C_DEF       = 8;
    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 16;
    localparam int MAXHOLD_DEF = 4;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Core-side request bus and dmem-side access bus of the arbiter.
interface mem_rr_arbiter_if #(
    parameter int C  = 8,
    parameter int AW = 16,
    parameter int DW = 16
) ();
    logic [C-1:0]          req;
    logic [C-1:0]          we;
    logic [C-1:0]          hold;
    logic [C-1:0][AW-1:0]  adr;
    logic [C-1:0][DW-1:0]  wdat;
    logic [C-1:0]          gnt;
    logic [C-1:0]          done;
    logic [DW-1:0]         rdat;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_adr;
    logic [DW-1:0]         mem_wdat;
    logic [DW-1:0]         mem_rdat;

    modport slave (
        input  req, we, hold, adr, wdat, mem_rdat,
        output gnt, done, rdat, mem_en, mem_we, mem_adr, mem_wdat
    );

    modport master (
        output req, we, hold, adr, wdat, mem_rdat,
        input  gnt, done, rdat, mem_en, mem_we, mem_adr, mem_wdat
    );
endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request at or after ptr, modulo C.
module rr_pick #(
    parameter int C  = 8,
    parameter int PW = 3
) (
    input  logic [C-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          valid
);

    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] j;
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        j     = '0;
        for (int i = 0; i < C; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(C))
                sum = sum - (PW+1)'(C);
            j = sum[PW-1:0];
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing the single-port dmem among C cores, with
// bounded hold bursts so an owner can do several beats per turn.
//   state  | meaning
//   IDLE   | no owner; pick next requester from ptr
//   ACCESS | owner's access driven onto dmem
//   RESP   | done pulse + read data; continue burst or release
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int C       = C_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MAXHOLD = MAXHOLD_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_rr_arbiter_if.slave bus
);

    localparam int PW = (C > 1) ? $clog2(C) : 1;
    localparam int BW = $clog2(MAXHOLD) + 1;

    arb_state_t    state, state_d;
    logic [PW-1:0] owner, owner_d;
    logic [PW-1:0] ptr, ptr_d;
    logic [BW-1:0] beat, beat_d;
    logic          wr, wr_d;
    logic          kept, kept_d;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;

    rr_pick #(.C(C), .PW(PW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            beat  <= '0;
            wr    <= 1'b0;
            kept  <= 1'b0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            ptr   <= ptr_d;
            beat  <= beat_d;
            wr    <= wr_d;
            kept  <= kept_d;
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        ptr_d   = ptr;
        beat_d  = beat;
        wr_d    = wr;
        kept_d  = kept;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    beat_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Direction and request liveness are frozen here so a core
                // dropping req mid-beat still gets a well-formed response.
                wr_d    = bus.we[owner];
                kept_d  = bus.req[owner];
                state_d = RESP;
            end
            RESP: begin
                if (kept && bus.req[owner] && bus.hold[owner] &&
                    beat < BW'(MAXHOLD - 1)) begin
                    beat_d  = beat + BW'(1);
                    state_d = ACCESS;
                end else begin
                    ptr_d   = (owner == PW'(C - 1)) ? '0 : owner + PW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt      = '0;
        bus.done     = '0;
        bus.rdat     = '0;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_adr  = '0;
        bus.mem_wdat = '0;
        case (state)
            ACCESS: begin
                bus.gnt[owner] = 1'b1;
                bus.mem_en     = 1'b1;
                bus.mem_we     = bus.we[owner];
                bus.mem_adr    = bus.adr[owner];
                bus.mem_wdat   = bus.wdat[owner];
            end
            RESP: begin
                bus.gnt[owner]  = 1'b1;
                bus.done[owner] = 1'b1;
                bus.rdat        = wr ? '0 : bus.mem_rdat;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter and access sequencer that shares the single-port data memory among C requesting cores. It sits between the per-core memory request interfaces and the `dmem` macro. It grants one core at a time and drives the memory address, data and write-enable for that core. It returns read data with a done pulse, and supports bounded hold bursts so a core can perform several back-to-back accesses without re-arbitrating.

## Interface
- `C`, 8, number of requesters (2..8)
- `AW`, 16, address width
- `DW`, 16, data width
- `MAXHOLD`, 4, maximum beats per grant when hold is used (1..8)
- `clk` in 1: single clock, all state updates on posedge
- `reset_n` in 1: reset is asynchronous and active-low
- `req` in C: per-core access request, level
- `we` in C: per-core write (1) / read (0)
- `hold` in C: owner wants another beat after the current one
- `adr` in AW×C: per-core address
- `wdat` in DW×C: per-core write data
- `gnt` out C: one-hot current owner, 0 when idle
- `done` out C: one-hot, 1-cycle pulse when owner's beat completes
- `rdat` out DW: read data, valid with `done`, 0 otherwise
- `mem_en` out 1: memory access strobe
- `mem_we` out 1: memory write enable
- `mem_adr` out AW: memory address
- `mem_wdat` out DW: memory write data
- `mem_rdat` in DW: memory read data, 1-cycle latency after `mem_en`

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if `req` nonzero, pick the first set bit at or after `ptr`, searching modulo C. Latch the pick as `owner`, clear `beat`, go to ACCESS. Otherwise stay in IDLE.
- ACCESS: `mem_en`=1. `mem_we`=`we[owner]`, `mem_adr`=`adr[owner]`, `mem_wdat`=`wdat[owner]`. All are sampled this cycle. Next state is RESP.
- RESP: `done[owner]`=1, `rdat`=`mem_rdat` (reads), `rdat`=0 (writes).
  - If `hold[owner]` and `beat` < MAXHOLD-1: `beat`++, go to ACCESS with the same owner.
  - Otherwise go to IDLE and set `ptr`=`owner`+1 mod C.
- `gnt[owner]`=1 in ACCESS and RESP; `gnt`=0 in IDLE.
- Requester protocol:
  - Keep `req`, `we`, `adr` and `wdat` stable from request until `done`.
  - Present the next beat's `adr`/`we`/`wdat` in the cycle after `done` when holding.
  - Drop `req` in the cycle after the final `done`.
- If `req[owner]` drops mid-beat, the beat still completes (ACCESS→RESP) and `done` still pulses. Hold is then ignored and the FSM returns to IDLE.
- `hold` outside RESP has no effect. `hold` of a non-owner is ignored.
- `ptr` advances only when a grant ends, so a burst counts as one turn.
- Reset (asynchronous, any state): state=IDLE, `ptr`=0, `owner`=0, `beat`=0. All outputs are 0 immediately, including `mem_en`, so an in-flight access is abandoned with no `done`.

## Timing
- Single beat: `req` seen in IDLE in cycle t → `gnt`/`mem_en` in t+1 → `done`/`rdat` in t+2 → IDLE in t+3. Earliest next grant is t+4 `gnt`.
- Burst of n beats (n ≤ MAXHOLD): `done` in cycles t+2, t+4, …, t+2n; IDLE at t+2n+1.
- Worst-case wait from `req` to `gnt` is (C-1)·(2·MAXHOLD+1)+2 cycles.
- `gnt`, `mem_*`, `done` and `rdat` are decoded from registered state/`owner`/`beat` plus the current-cycle inputs. There is no combinational path from `req` to any output.
- `beat` width is $clog2(MAXHOLD)+1. `ptr` and `owner` width is $clog2(C). The pointer wraps from C-1 to 0.

## Structure
- Package `mem_arb_pkg` contains:
  - the state enum `arb_state_t` {IDLE, ACCESS, RESP};
  - constants for the default C/AW/DW/MAXHOLD.
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs are `req` and `ptr`; outputs are index and valid. It is instantiated once.
- The top level holds the FSM, `owner`/`ptr`/`beat` registers and the output muxes.

## Test plan
- Single read: core 2 reads `adr`=0x0010 while memory holds 0xBEEF there. Expected: `gnt`=0x04 at t+1, `mem_adr`=0x0010 with `mem_we`=0, then `done`=0x04 and `rdat`=0xBEEF at t+2.
- All cores request simultaneously from reset, one beat each. Expected: grant order 0,1,…,7. Repeat with all requests held: order is 0..7 again, with no core granted twice before every other requester.
- Burst: core 5 has `hold`=1 for 6 beats with MAXHOLD=4. Expected: exactly 4 `done` pulses, then `gnt` drops, core 6 (pending) is granted next, and core 5 regains the grant afterwards.
- Write then read: core 1 writes 0x1234 to 0x0FFF, then core 3 reads 0x0FFF. Expected: `mem_we`=1 only in core 1's ACCESS cycle, and core 3 gets `rdat`=0x1234.
- Reset mid-burst: assert `reset_n`=0 during ACCESS. Expected: `mem_en`, `gnt` and `done` go to 0 immediately (asynchronously). After release, the first grant goes to the lowest pending index, since `ptr`=0.
- Dropped request: core 4 deasserts `req` during ACCESS with `hold`=1. Expected: `done`=0x10 in RESP, then IDLE, with no further beat.
